// File: rtl/parity_checker_if.sv
// Word/parity input channel and registered result channel of the parity checker.
// master = source/sink side (bench or upstream), slave = the checker itself.
interface parity_checker_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              parity_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, data_in, parity_in, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, data_in, parity_in, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_checker.sv
// Parity checker: 1-cycle registered pass/fail per word; in_ready = empty | out_ready (no bubble).
// Byte/error counters with sticky flag; PARITY_ERR_LOG_EN adds first-error capture.
module parity_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_checker_if.slave   bus,
  input  logic              clr,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  byte_count,
  output logic [CNT_W-1:0]  err_count
`ifdef PARITY_ERR_LOG_EN
  ,
  output logic [DATA_W-1:0] first_err_data,
  output logic              first_err_valid
`endif
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_consume;
  logic               w_mismatch;
  logic               w_odd;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_err;
  logic               r_err_sticky;
  logic [CNT_W-1:0]   r_byte_count;
  logic [CNT_W-1:0]   r_err_count;

  assign w_odd      = (ODD != 0);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_consume  = w_out_valid & bus.out_ready;
  assign w_mismatch = ((^bus.data_in) ^ w_odd) != bus.parity_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next_state;
  end

  // In FULL an accept always coincides with a consume, so FULL persists.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_next_state = S_FULL;
      S_FULL:  if (w_consume && !w_accept) w_next_state = S_EMPTY;
      default: w_next_state = S_EMPTY;
    endcase
  end

  always_comb begin
    w_out_valid = 1'b0;
    w_in_ready  = 1'b1;
    case (r_state)
      S_EMPTY: begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b1;
      end
      S_FULL: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else if (w_accept) begin
      r_out_data <= bus.data_in;
      r_out_err  <= w_mismatch;
    end
  end

  // clr wipes history first; a coincident accept is then the only word counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_count <= '0;
      r_err_count  <= '0;
      r_err_sticky <= 1'b0;
    end else if (clr) begin
      r_byte_count <= CNT_W'(w_accept);
      r_err_count  <= CNT_W'(w_accept & w_mismatch);
      r_err_sticky <= w_accept & w_mismatch;
    end else if (w_accept) begin
      r_byte_count <= r_byte_count + CNT_W'(1);
      if (w_mismatch) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

`ifdef PARITY_ERR_LOG_EN
  logic [DATA_W-1:0] r_first_err_data;
  logic              r_first_err_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_err_data  <= '0;
      r_first_err_valid <= 1'b0;
    end else if (clr) begin
      r_first_err_data  <= (w_accept && w_mismatch) ? bus.data_in : '0;
      r_first_err_valid <= w_accept & w_mismatch;
    end else if (w_accept && w_mismatch && !r_first_err_valid) begin
      r_first_err_data  <= bus.data_in;
      r_first_err_valid <= 1'b1;
    end
  end

  assign first_err_data  = r_first_err_data;
  assign first_err_valid = r_first_err_valid;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
  assign err_sticky    = r_err_sticky;
  assign byte_count    = r_byte_count;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_parity_checker.sv
// Directed plus random bench for parity_checker (even parity, 4-bit counters) against a transaction-level model.
module tb_parity_checker;
  localparam int DATA_W = 8;
  localparam int ODD    = 0;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             err_sticky;
  logic [CNT_W-1:0] byte_count;
  logic [CNT_W-1:0] err_count;
`ifdef PARITY_ERR_LOG_EN
  logic [DATA_W-1:0] first_err_data;
  logic              first_err_valid;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  parity_checker_if #(.DATA_W(DATA_W)) bus ();

  parity_checker #(.DATA_W(DATA_W), .ODD(ODD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr        (clr),
    .err_sticky (err_sticky),
    .byte_count (byte_count),
    .err_count  (err_count)
`ifdef PARITY_ERR_LOG_EN
    ,
    .first_err_data  (first_err_data),
    .first_err_valid (first_err_valid)
`endif
  );

  always #5 clk = ~clk;

  // Reference state: one held result slot plus counters, as plain integers.
  bit              m_vld;
  logic [7:0]      m_data;
  bit              m_err;
  int              m_bytes;
  int              m_errs;
  bit              m_sticky;
  bit              m_fe_vld;
  logic [7:0]      m_fe_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_err = 0;
    m_bytes = 0; m_errs = 0; m_sticky = 0;
    m_fe_vld = 0; m_fe_data = '0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".out_err"},   32'(bus.out_err),   32'(m_err));
    chk({tag, ".sticky"},    32'(err_sticky),    32'(m_sticky));
    chk({tag, ".byte_cnt"},  32'(byte_count),    32'(m_bytes));
    chk({tag, ".err_cnt"},   32'(err_count),     32'(m_errs));
`ifdef PARITY_ERR_LOG_EN
    chk({tag, ".fe_valid"},  32'(first_err_valid), 32'(m_fe_vld));
    chk({tag, ".fe_data"},   32'(first_err_data),  32'(m_fe_data));
`endif
  endtask

  // One clock of stimulus: drive at negedge, check in_ready, advance model on posedge, check after.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic p,
                      input logic ordy, input logic c);
    bit acc, cons, mis;
    @(negedge clk);
    bus.in_valid = v; bus.data_in = d; bus.parity_in = p; bus.out_ready = ordy; clr = c;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!m_vld || ordy));
    @(posedge clk);
    acc  = (v === 1'b1) && (!m_vld || ordy);
    cons = m_vld && ordy;
    mis  = acc ? ((($countones(d) + int'(p)) % 2) != ODD) : 1'b0;
    if (c) begin
      m_bytes = 0; m_errs = 0; m_sticky = 0; m_fe_vld = 0; m_fe_data = '0;
    end
    if (acc) begin
      m_data  = d;
      m_err   = mis;
      m_bytes = (m_bytes + 1) % (1 << CNT_W);
      if (mis) begin
        m_sticky = 1;
        if (m_errs < (1 << CNT_W) - 1) m_errs++;
        if (!m_fe_vld) begin m_fe_vld = 1; m_fe_data = d; end
      end
    end
    m_vld = acc ? 1'b1 : (cons ? 1'b0 : m_vld);
    #1;
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; clr = 1'b0;
    #1;
    model_reset();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.parity_in = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    do_reset();

    // Even parity, all good, streaming
    step("ev0", 1, 8'hBD, 0, 1, 0);
    step("ev1", 1, 8'h04, 1, 1, 0);
    step("ev2", 1, 8'h64, 1, 1, 0);
    step("ev3", 1, 8'hFF, 0, 1, 0);
    chk("ev.byte4", 32'(byte_count), 32'd4);
    chk("ev.err0",  32'(err_count),  32'd0);

    // Corrupted parity then good word: sticky holds
    step("bad0", 1, 8'h04, 0, 1, 0);
    chk("bad0.err", 32'(bus.out_err), 32'd1);
    step("good", 1, 8'hFF, 0, 1, 0);
    chk("good.sticky", 32'(err_sticky), 32'd1);
    step("drain", 0, 'x, 'x, 1, 0);

    // Backpressure: second word waits, then swap in the same cycle
    step("bp0", 1, 8'hBD, 0, 0, 0);
    step("bp1", 1, 8'h64, 1, 0, 0);
    chk("bp1.hold", 32'(bus.out_data), 32'hBD);
    step("bp2", 1, 8'h64, 1, 1, 0);
    chk("bp2.swap", 32'(bus.out_data), 32'h64);
    step("bp3", 0, 'x, 'x, 1, 0);

    // Saturating error counter, wrapping byte counter
    do_reset();
    for (int i = 0; i < 17; i++) step("sat", 1, 8'h04, 0, 1, 0);
    chk("sat.err", 32'(err_count),  32'hF);
    chk("sat.byte", 32'(byte_count), 32'h1);

    // clr coincident with a bad accept
    do_reset();
    for (int i = 0; i < 3; i++) step("pre", 1, 8'h04, 0, 1, 0);
    step("clracc", 1, 8'h04, 0, 1, 1);
    chk("clracc.byte", 32'(byte_count), 32'd1);
    chk("clracc.err",  32'(err_count),  32'd1);

    // Asynchronous reset while FULL
    step("full", 1, 8'h5A, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.in_ready",  32'(bus.in_ready),  32'd1);
    model_reset();
    do_reset();

`ifdef PARITY_ERR_LOG_EN
    step("log0", 1, 8'h64, 0, 1, 0);
    step("log1", 1, 8'hFF, 1, 1, 0);
    chk("log.data", 32'(first_err_data),  32'h64);
    chk("log.vld",  32'(first_err_valid), 32'd1);
    step("logclr", 0, 'x, 'x, 1, 1);
    chk("logclr.vld", 32'(first_err_valid), 32'd0);
`endif

    // Random traffic with X on idle data and occasional clr
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [7:0] d;
      logic       p;
      v = 1'($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      p = 1'($urandom);
      if (!v && $urandom_range(0, 1) == 1) begin d = 'x; p = 'x; end
      step("rnd", v, d, p, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/parity_checker.md
Name: parity_checker

Overview:
- Receiving end of the 8-bit parity stimulus/generator path: accepts a data word plus a transmitted parity bit over a valid/ready handshake.
- Recomputes parity and registers a pass/fail result downstream.
- Maintains a byte counter, a saturating error counter and a sticky error flag.
- Sits after the parity generator in the datapath and is the self-checking endpoint for parity benches.

Parameters:
- DATA_W, 8, data word width in bits.
- ODD, 0, parity sense: 0 = even (parity bit = XOR of data), 1 = odd (parity bit = ~XOR of data).
- CNT_W, 16, width of the byte and error counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in/parity_in are valid.
- in_ready  output  1  checker can accept a word this cycle.
- data_in  input  DATA_W  received data word.
- parity_in  input  1  received parity bit.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream consumes the result.
- out_data  output  DATA_W  registered copy of the accepted word.
- out_err  output  1  1 = parity mismatch on out_data.
- err_sticky  output  1  set on any mismatch; held until clr.
- byte_count  output  CNT_W  words accepted since reset/clr.
- err_count  output  CNT_W  mismatches since reset/clr, saturating.
- clr  input  1  synchronous clear of counters and sticky flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=EMPTY, out_valid=0, out_data=0, out_err=0, err_sticky=0, byte_count=0, err_count=0. in_ready follows the state rule below, so it reads 1 while in reset.
- Accept condition: in_valid & in_ready on a rising edge.
- Consume condition: out_valid & out_ready on a rising edge.
- Computation: exp = ^data_in ^ ODD; mismatch = exp != parity_in.
- FSM, two states:
  - EMPTY (out_valid=0): in_ready=1. On accept, go to FULL and load out_data=data_in, out_err=mismatch.
  - FULL (out_valid=1): in_ready=out_ready, so a word can be accepted in the same cycle the held result is consumed.
    - Consume and accept in the same cycle: stay FULL and reload registers with the new word.
    - Consume without accept: go to EMPTY.
    - Neither: hold all result registers stable.
- Latency: one cycle from accept to out_valid. Throughput: one word per cycle when out_ready is held high.
- Counters on accept:
  - byte_count += 1, wrapping modulo 2^CNT_W.
  - If mismatch, err_count += 1, saturating at all-ones, and err_sticky is set.
- clr (synchronous, 1 cycle):
  - Zeroes byte_count and err_count, clears err_sticky.
  - Does not affect the FSM or result registers.
  - clr and an accept in the same cycle: clr wins for the clear, then the accepted word is counted, so byte_count=1 and err_count/err_sticky reflect only that word.
- Rules:
  - in_ready must not depend on in_valid.
  - Input signals are ignored when no accept occurs.
  - X on data_in while in_valid=0 must not propagate.
- Reset mid-transfer: any held result is discarded and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro PARITY_ERR_LOG_EN.
- Defined: adds outputs first_err_data (DATA_W) and first_err_valid (1), both reset to 0.
  - On the first mismatching accept while first_err_valid=0, capture data_in and set first_err_valid.
  - Later errors do not overwrite the capture; clr clears both outputs.
- Undefined: neither port nor its logic exists; the rest of the block is unchanged.

Test Plan:
- Reset then even parity (ODD=0): send 8'hBD/p=0, 8'h04/p=1, 8'h64/p=1, 8'hFF/p=0 with out_ready=1 -> four results with out_err=0, out_data matches each word one cycle after accept, byte_count=4, err_count=0, err_sticky=0.
- Corrupted parity: send 8'h04/p=0 -> out_err=1, err_sticky=1, err_count=1. Then send 8'hFF/p=0 -> out_err=0 while err_sticky stays 1.
- Backpressure: hold out_ready=0 and send 8'hBD then 8'h64 -> in_ready=0 after the first accept and out_data stays 8'hBD. Raise out_ready -> 8'hBD consumed and 8'h64 accepted in the same cycle, with no loss or duplication.
- Saturation/wrap with CNT_W=4: send 17 bad words -> err_count=4'hF, byte_count=4'h1.
- clr coincident with accept of a bad word after 3 earlier errors -> byte_count=1, err_count=1, err_sticky=1. Also assert rst_n low while FULL -> out_valid drops immediately, without waiting for a clock edge.
- PARITY_ERR_LOG_EN defined: send 8'h64/p=0 then 8'hFF/p=1 -> first_err_data=8'h64, first_err_valid=1. clr -> first_err_data=0, first_err_valid=0.
